// File: rtl/multi_strip_driver.sv
// Parallel xx6812 LED strip driver: double-buffered frame storage, all strips
// serialised in lock-step, followed by an all-low latch period.
module multi_strip_driver #(
   parameter int unsigned NUM_STRIPS     = 4,
   parameter int unsigned LEDS_PER_STRIP = 60,
   parameter int unsigned BITS_PER_LED   = 24,
   parameter int unsigned CYCLES_PER_BIT = 15,
   parameter int unsigned T0H_CYCLES     = 4,
   parameter int unsigned T1H_CYCLES     = 9,
   parameter int unsigned LATCH_CYCLES   = 960,
   localparam int unsigned SW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1,
   localparam int unsigned LW = (LEDS_PER_STRIP > 1) ? $clog2(LEDS_PER_STRIP) : 1
) (
   input  logic                    clock_12mhz,
   input  logic                    reset_n,
   input  logic                    write_enable,
   input  logic [SW-1:0]           write_strip,
   input  logic [LW-1:0]           write_led,
   input  logic [BITS_PER_LED-1:0] write_data,
   input  logic                    frame_start,
   output logic                    busy,
   output logic                    frame_done,
   output logic [NUM_STRIPS-1:0]   strip
);

   localparam int unsigned PW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int unsigned BW = $clog2(BITS_PER_LED);
   localparam int unsigned CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   // Reject bit timings that cannot produce distinguishable 0/1 pulses.
   if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < CYCLES_PER_BIT)) ||
       !((BITS_PER_LED == 24) || (BITS_PER_LED == 32))) begin : g_param_check
      $error("multi_strip_driver: illegal bit timing or BITS_PER_LED");
   end

   typedef enum logic [1:0] {IDLE, LOAD, BIT, LATCH} state_t;

   state_t                                   state;
   logic                                     sel;
   logic                                     pending;
   logic [PW-1:0]                            phase;
   logic [BW-1:0]                            bit_cnt;
   logic [LW-1:0]                            led_cnt;
   logic [LW-1:0]                            next_led;
   logic [CW-1:0]                            latch_cnt;
   logic [NUM_STRIPS-1:0][BITS_PER_LED-1:0]  shreg;
   logic                                     write_ok;

   // Two frame buffers; sel picks the one being transmitted (front).
   logic [BITS_PER_LED-1:0] frame_mem [2][NUM_STRIPS][LEDS_PER_STRIP];

   assign write_ok = write_enable &&
                     (32'(write_strip) < NUM_STRIPS) &&
                     (32'(write_led) < LEDS_PER_STRIP);

   // Host writes always land in the back buffer; contents survive reset.
   always_ff @(posedge clock_12mhz) begin
      if (write_ok) frame_mem[~sel][write_strip][write_led] <= write_data;
   end

   // LED index to prefetch at the end of the current LED, held at the last LED.
   always_comb begin
      next_led = led_cnt;
      if (led_cnt != LW'(LEDS_PER_STRIP - 1)) next_led = led_cnt + LW'(1);
   end

   // Frame sequencer: swap/launch, parallel bit serialiser, latch timing.
   always_ff @(posedge clock_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sel        <= 1'b0;
         pending    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         strip      <= '0;
         phase      <= '0;
         bit_cnt    <= '0;
         led_cnt    <= '0;
         latch_cnt  <= '0;
         shreg      <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  sel     <= ~sel;
                  led_cnt <= '0;
                  bit_cnt <= '0;
                  phase   <= '0;
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            end

            LOAD: begin
               if (frame_start) pending <= 1'b1;
               for (int i = 0; i < NUM_STRIPS; i++) shreg[i] <= frame_mem[sel][i][led_cnt];
               // Every bit period opens high, so the first cycle needs no data yet.
               strip <= '1;
               phase <= '0;
               state <= BIT;
            end

            BIT: begin
               if (frame_start) pending <= 1'b1;
               if (phase == PW'(CYCLES_PER_BIT - 1)) begin
                  phase <= '0;
                  if (bit_cnt == BW'(BITS_PER_LED - 1)) begin
                     bit_cnt <= '0;
                     if (led_cnt == LW'(LEDS_PER_STRIP - 1)) begin
                        strip     <= '0;
                        latch_cnt <= '0;
                        state     <= LATCH;
                     end else begin
                        // Next LED is fetched at the last bit boundary: no inter-LED gap.
                        led_cnt <= next_led;
                        for (int i = 0; i < NUM_STRIPS; i++) shreg[i] <= frame_mem[sel][i][next_led];
                        strip   <= '1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     for (int i = 0; i < NUM_STRIPS; i++)
                        shreg[i] <= {shreg[i][BITS_PER_LED-2:0], 1'b0};
                     strip   <= '1;
                  end
               end else begin
                  phase <= phase + PW'(1);
                  for (int i = 0; i < NUM_STRIPS; i++)
                     strip[i] <= (32'(phase) + 32'd1) <
                                 (shreg[i][BITS_PER_LED-1] ? T1H_CYCLES : T0H_CYCLES);
               end
            end

            LATCH: begin
               if (latch_cnt == CW'(LATCH_CYCLES - 1)) begin
                  frame_done <= 1'b1;
                  latch_cnt  <= '0;
                  if (pending || frame_start) begin
                     pending <= 1'b0;
                     sel     <= ~sel;
                     led_cnt <= '0;
                     bit_cnt <= '0;
                     phase   <= '0;
                     state   <= LOAD;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  if (frame_start) pending <= 1'b1;
                  latch_cnt <= latch_cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
